// File: rtl/dfd_te_bthb_mp.sv
// Multi-port branch target history buffer: compacts sparse retire lanes into a
// circular store and presents the oldest NUM_RD entries to the packet formatter.
module dfd_te_bthb_mp #(
  parameter int unsigned NUM_WR         = 8,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ENTRY_WIDTH    = 25,
  parameter int unsigned TSTAMP_EN      = 0,
  parameter int unsigned TSTAMP_WIDTH   = 64,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_WR-1:0]                wr_vld,
  input  logic [NUM_WR*ENTRY_WIDTH-1:0]    wr_data,
  input  logic [TSTAMP_WIDTH-1:0]          tstamp_in,
  output logic [NUM_RD-1:0]                rd_vld,
  output logic [NUM_RD*ENTRY_WIDTH-1:0]    rd_data,
  output logic [NUM_RD*TSTAMP_WIDTH-1:0]   rd_tstamp,
  input  logic [NUM_RD-1:0]                rd_pop,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             overflow,
  output logic [DROP_CNT_WIDTH-1:0]        drop_cnt,
  input  logic                             overflow_clr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = DROP_CNT_WIDTH + AW;
  localparam logic [AW-1:0] DEPTH_A  = DEPTH[AW-1:0];
  localparam logic [SW-1:0] DROP_MAX = {{AW{1'b0}}, {DROP_CNT_WIDTH{1'b1}}};

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          wr_addr [NUM_WR];
  logic [PW-1:0]          rd_addr [NUM_RD];
  logic [AW-1:0]          w_cnt;
  logic [AW-1:0]          w_acc;
  logic [AW-1:0]          p_cnt;
  logic [AW-1:0]          free_slots;
  logic                   accept;
  logic                   do_wr;
  logic                   drop;
  logic                   pop_run;
  logic [SW-1:0]          drop_sum;

  // Offset is at most DEPTH, so a single conditional subtract wraps it.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [AW-1:0] off);
    logic [AW-1:0] s;
    s = {1'b0, base} + off;
    if (s >= DEPTH_A) s = s - DEPTH_A;
    return s[PW-1:0];
  endfunction

  // Each valid lane lands after the valid lanes below it.
  always_comb begin
    w_cnt = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wr_addr[k] = wrap_add(wr_ptr, w_cnt);
      w_cnt      = w_cnt + AW'(wr_vld[k]);
    end
  end

  // Admission uses the pre-pop occupancy; a group is taken whole or not at all.
  always_comb begin
    free_slots = DEPTH_A - AW'(cnt_q);
    accept     = (w_cnt <= free_slots);
    do_wr      = accept & ~flush;
    drop       = ~accept & ~flush;
    w_acc      = accept ? w_cnt : '0;
    drop_sum   = (overflow_clr ? '0 : SW'(drop_cnt)) + SW'(w_cnt);
  end

  always_comb begin
    p_cnt   = '0;
    pop_run = 1'b1;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      pop_run = pop_run & rd_pop[i] & rd_vld[i];
      p_cnt   = p_cnt + AW'(pop_run);
    end
  end

  always_comb begin
    rd_vld  = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_vld[i]  = (AW'(cnt_q) > AW'(i));
      rd_addr[i] = wrap_add(rd_ptr, AW'(i));
      rd_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem[rd_addr[i]];
    end
  end

  assign count = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else if (do_wr) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_vld[k]) mem[wr_addr[k]] <= wr_data[k*ENTRY_WIDTH +: ENTRY_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      rd_ptr <= wrap_add(rd_ptr, p_cnt);
      wr_ptr <= wrap_add(wr_ptr, w_acc);
      cnt_q  <= CW'(AW'(cnt_q) + w_acc - p_cnt);
    end
  end

  // A drop in the same cycle as a clear restarts the count at this group's size.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end else if (overflow_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  if (TSTAMP_EN != 0) begin : g_ts
    logic [TSTAMP_WIDTH-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned d = 0; d < DEPTH; d++) ts_mem[d] <= '0;
      end else if (do_wr) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wr_vld[k]) ts_mem[wr_addr[k]] <= tstamp_in;
        end
      end
    end

    always_comb begin
      rd_tstamp = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        rd_tstamp[i*TSTAMP_WIDTH +: TSTAMP_WIDTH] = ts_mem[rd_addr[i]];
      end
    end
  end else begin : g_no_ts
    logic unused_tstamp;
    assign unused_tstamp = ^tstamp_in;
    assign rd_tstamp     = '0;
  end

  a_pop_thermo: assert property (@(posedge clk) disable iff (!reset_n)
    ((rd_pop & (rd_pop + NUM_RD'(1))) == '0))
    else $error("rd_pop is not a thermometer code");

endmodule

// File: tb/tb_dfd_te_bthb_mp.sv
// Directed bench for dfd_te_bthb_mp: a 16-deep untimestamped instance and a
// 10-deep timestamped instance driven by shared stimulus.
module tb_dfd_te_bthb_mp;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   wr_vld;
  logic [199:0] wr_data;
  logic [63:0]  tstamp_in;
  logic [1:0]   rd_pop;
  logic         flush;
  logic         overflow_clr;

  logic [1:0]   a_rd_vld;
  logic [49:0]  a_rd_data;
  logic [127:0] a_rd_tstamp;
  logic [4:0]   a_count;
  logic         a_overflow;
  logic [7:0]   a_drop_cnt;

  logic [1:0]   b_rd_vld;
  logic [49:0]  b_rd_data;
  logic [127:0] b_rd_tstamp;
  logic [3:0]   b_count;
  logic         b_overflow;
  logic [7:0]   b_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dfd_te_bthb_mp dut_a (
    .clk(clk), .reset_n(reset_n), .wr_vld(wr_vld), .wr_data(wr_data),
    .tstamp_in(tstamp_in), .rd_vld(a_rd_vld), .rd_data(a_rd_data),
    .rd_tstamp(a_rd_tstamp), .rd_pop(rd_pop), .flush(flush), .count(a_count),
    .overflow(a_overflow), .drop_cnt(a_drop_cnt), .overflow_clr(overflow_clr)
  );

  dfd_te_bthb_mp #(.DEPTH(10), .TSTAMP_EN(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_vld(wr_vld), .wr_data(wr_data),
    .tstamp_in(tstamp_in), .rd_vld(b_rd_vld), .rd_data(b_rd_data),
    .rd_tstamp(b_rd_tstamp), .rd_pop(rd_pop), .flush(flush), .count(b_count),
    .overflow(b_overflow), .drop_cnt(b_drop_cnt), .overflow_clr(overflow_clr)
  );

  typedef struct {
    logic [7:0]  vld;
    logic [1:0]  pop;
    logic        fl;
    logic        clr;
    int          cnt;
    logic [1:0]  rv;
    logic [24:0] d0;
    logic [24:0] d1;
    logic        ov;
    int          dc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Lane k of a write carries base + k; one call is one clock, sampled 1ns after the edge.
  task automatic cyc(input logic [7:0] v, input logic [1:0] p, input logic fl,
                     input logic clr, input int base);
    wr_vld       = v;
    rd_pop       = p;
    flush        = fl;
    overflow_clr = clr;
    for (int k = 0; k < 8; k++) wr_data[k*25 +: 25] = 25'(base + k);
    @(posedge clk);
    #1;
    wr_vld       = '0;
    rd_pop       = '0;
    flush        = 1'b0;
    overflow_clr = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    wr_vld       = '0;
    wr_data      = '0;
    tstamp_in    = 64'h5555;
    rd_pop       = '0;
    flush        = 1'b0;
    overflow_clr = 1'b0;

    tbl[0]  = '{8'h05, 2'b00, 1'b0, 1'b0,  2, 2'b11, 25'h10, 25'h12, 1'b0, 0};
    tbl[1]  = '{8'h92, 2'b00, 1'b0, 1'b0,  5, 2'b11, 25'h10, 25'h12, 1'b0, 0};
    tbl[2]  = '{8'h00, 2'b11, 1'b0, 1'b0,  3, 2'b11, 25'h21, 25'h24, 1'b0, 0};
    tbl[3]  = '{8'h00, 2'b11, 1'b0, 1'b0,  1, 2'b01, 25'h27, 25'h00, 1'b0, 0};
    tbl[4]  = '{8'hFF, 2'b01, 1'b0, 1'b0,  8, 2'b11, 25'h50, 25'h51, 1'b0, 0};
    tbl[5]  = '{8'h7F, 2'b00, 1'b0, 1'b0, 15, 2'b11, 25'h50, 25'h51, 1'b0, 0};
    tbl[6]  = '{8'h03, 2'b00, 1'b0, 1'b0, 15, 2'b11, 25'h50, 25'h51, 1'b1, 2};
    tbl[7]  = '{8'h01, 2'b00, 1'b0, 1'b0, 16, 2'b11, 25'h50, 25'h51, 1'b1, 2};
    tbl[8]  = '{8'h03, 2'b11, 1'b0, 1'b0, 14, 2'b11, 25'h52, 25'h53, 1'b1, 4};
    tbl[9]  = '{8'h00, 2'b00, 1'b0, 1'b1, 14, 2'b11, 25'h52, 25'h53, 1'b0, 0};
    tbl[10] = '{8'h07, 2'b00, 1'b0, 1'b0, 14, 2'b11, 25'h52, 25'h53, 1'b1, 3};
    tbl[11] = '{8'h07, 2'b00, 1'b0, 1'b1, 14, 2'b11, 25'h52, 25'h53, 1'b1, 3};
    tbl[12] = '{8'hFF, 2'b11, 1'b1, 1'b0,  0, 2'b00, 25'h63, 25'h64, 1'b1, 3};
    tbl[13] = '{8'h01, 2'b11, 1'b0, 1'b0,  1, 2'b01, 25'hE0, 25'h64, 1'b1, 3};

    #12;
    chk("reset_count",    64'(a_count),    64'd0);
    chk("reset_rd_vld",   64'(a_rd_vld),   64'd0);
    chk("reset_rd_data",  64'(a_rd_data),  64'd0);
    chk("reset_overflow", 64'(a_overflow), 64'd0);
    chk("reset_drop_cnt", 64'(a_drop_cnt), 64'd0);
    chk("reset_ts_b",     b_rd_tstamp[63:0], 64'd0);
    #10 reset_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      cyc(tbl[v].vld, tbl[v].pop, tbl[v].fl, tbl[v].clr, (v + 1) * 16);
      chk($sformatf("v%0d_count", v),    64'(a_count),           64'(tbl[v].cnt));
      chk($sformatf("v%0d_rd_vld", v),   64'(a_rd_vld),          64'(tbl[v].rv));
      chk($sformatf("v%0d_rd_data0", v), 64'(a_rd_data[24:0]),   64'(tbl[v].d0));
      chk($sformatf("v%0d_rd_data1", v), 64'(a_rd_data[49:25]),  64'(tbl[v].d1));
      chk($sformatf("v%0d_overflow", v), 64'(a_overflow),        64'(tbl[v].ov));
      chk($sformatf("v%0d_drop_cnt", v), 64'(a_drop_cnt),        64'(tbl[v].dc));
    end

    // Drop counter saturation on a full 16-entry buffer.
    cyc(8'h00, 2'b00, 1'b1, 1'b0, 0);
    cyc(8'hFF, 2'b00, 1'b0, 1'b0, 0);
    cyc(8'hFF, 2'b00, 1'b0, 1'b0, 0);
    chk("sat_full_count", 64'(a_count), 64'd16);
    cyc(8'h00, 2'b00, 1'b0, 1'b1, 0);
    chk("sat_clr_ov", 64'(a_overflow), 64'd0);
    chk("sat_clr_dc", 64'(a_drop_cnt), 64'd0);
    for (int n = 0; n < 84; n++) cyc(8'h07, 2'b00, 1'b0, 1'b0, 0);
    chk("sat_dc_252", 64'(a_drop_cnt), 64'd252);
    for (int n = 0; n < 16; n++) cyc(8'h07, 2'b00, 1'b0, 1'b0, 0);
    chk("sat_dc_255", 64'(a_drop_cnt), 64'd255);
    chk("sat_ov",     64'(a_overflow), 64'd1);
    chk("sat_count",  64'(a_count),    64'd16);
    cyc(8'h00, 2'b00, 1'b0, 1'b1, 0);
    chk("sat_final_ov", 64'(a_overflow), 64'd0);
    chk("sat_final_dc", 64'(a_drop_cnt), 64'd0);

    // Wrap across index 9 -> 0 on the 10-deep timestamped instance.
    cyc(8'h00, 2'b00, 1'b1, 1'b0, 0);
    tstamp_in = 64'hAAAA;
    cyc(8'hFF, 2'b00, 1'b0, 1'b0, 32'h100);
    chk("wrap_fill_count", 64'(b_count), 64'd8);
    for (int n = 0; n < 4; n++) cyc(8'h00, 2'b11, 1'b0, 1'b0, 0);
    chk("wrap_empty_count", 64'(b_count), 64'd0);
    tstamp_in = 64'h1234;
    cyc(8'h3F, 2'b00, 1'b0, 1'b0, 32'h200);
    tstamp_in = 64'h0;
    chk("wrap_w6_count", 64'(b_count),            64'd6);
    chk("wrap_w6_d0",    64'(b_rd_data[24:0]),    64'h200);
    chk("wrap_w6_d1",    64'(b_rd_data[49:25]),   64'h201);
    chk("ts_b_0",        b_rd_tstamp[63:0],       64'h1234);
    chk("ts_b_1",        b_rd_tstamp[127:64],     64'h1234);
    chk("ts_a_lo_zero",  a_rd_tstamp[63:0],       64'd0);
    chk("ts_a_hi_zero",  a_rd_tstamp[127:64],     64'd0);
    cyc(8'h00, 2'b11, 1'b0, 1'b0, 0);
    chk("wrap_p1_d0", 64'(b_rd_data[24:0]),  64'h202);
    chk("wrap_p1_d1", 64'(b_rd_data[49:25]), 64'h203);
    cyc(8'h00, 2'b11, 1'b0, 1'b0, 0);
    chk("wrap_p2_d0", 64'(b_rd_data[24:0]),  64'h204);
    chk("wrap_p2_d1", 64'(b_rd_data[49:25]), 64'h205);
    cyc(8'h00, 2'b11, 1'b0, 1'b0, 0);
    chk("wrap_p3_count", 64'(b_count), 64'd0);
    cyc(8'h01, 2'b00, 1'b0, 1'b0, 32'h300);
    chk("wrap_wp4_d0",    64'(b_rd_data[24:0]), 64'h300);
    chk("wrap_wp4_count", 64'(b_count),         64'd1);
    chk("a_pre_rst_d0",   64'(a_rd_data[24:0]), 64'h300);
    chk("a_pre_rst_cnt",  64'(a_count),         64'd1);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count_a",  64'(a_count),          64'd0);
    chk("mid_rst_vld_a",    64'(a_rd_vld),         64'd0);
    chk("mid_rst_data_a",   64'(a_rd_data),        64'd0);
    chk("mid_rst_count_b",  64'(b_count),          64'd0);
    chk("mid_rst_data_b",   64'(b_rd_data),        64'd0);
    chk("mid_rst_ts_b",     b_rd_tstamp[63:0],     64'd0);
    #2 reset_n = 1'b1;
    cyc(8'h00, 2'b00, 1'b0, 1'b0, 0);
    chk("post_rst_count_a", 64'(a_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dfd_te_bthb_mp.md
# dfd_te_bthb_mp

Parametrised multi-port Branch Target History Buffer for the trace encoder. Accepts up to NUM_WR retire-packet entries per cycle on sparse write lanes, compacts them in lane order into a circular store of DEPTH entries, and presents the oldest NUM_RD entries to the packet formatter. Successor of the fixed 8-write/2-read, 10-entry BTHB: adds generic depth and port counts, optional per-entry timestamp capture, flush, whole-group drop on overflow with a sticky flag, and a saturating drop counter for RESOURCEFULL reporting.

## Interface

- NUM_WR, 8, write lanes (RETIRE_WIDTH)
- NUM_RD, 2, read ports (NUM_BLOCKS)
- DEPTH, 16, entries; any value ≥ max(NUM_WR, NUM_RD), power of two not required
- ENTRY_WIDTH, 25, bits per entry (BTHBPkt_s width)
- TSTAMP_EN, 0, 1 = store timestamp per entry
- TSTAMP_WIDTH, 64, timestamp bits
- DROP_CNT_WIDTH, 8, drop counter bits

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- wr_vld  in  NUM_WR  per-lane write valid; any pattern legal
- wr_data  in  NUM_WR×ENTRY_WIDTH  per-lane entry
- tstamp_in  in  TSTAMP_WIDTH  timestamp for this cycle's writes
- rd_vld  out  NUM_RD  rd_vld[i] = entry i (0 = oldest) present
- rd_data  out  NUM_RD×ENTRY_WIDTH  entry i
- rd_tstamp  out  NUM_RD×TSTAMP_WIDTH  timestamp of entry i; 0 when TSTAMP_EN=0
- rd_pop  in  NUM_RD  pop request; thermometer (bit i implies bits < i)
- flush  in  1  discard all contents
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write group was dropped
- drop_cnt  out  DROP_CNT_WIDTH  saturating count of dropped entries
- overflow_clr  in  1  clears overflow and drop_cnt

## Operation

- State: storage[DEPTH], rd_ptr, wr_ptr (0..DEPTH-1), count.
- Write group: W = popcount(wr_vld). Accepted iff W ≤ DEPTH − count (current-cycle count; same-cycle pops not credited). Accepted: lane k with j lower-indexed valid lanes lands at (wr_ptr + j) mod DEPTH; wr_ptr += W mod DEPTH. Rejected: nothing written, overflow ← 1, drop_cnt += W saturating at all-ones.
- TSTAMP_EN=1: every entry of an accepted group stores tstamp_in of that cycle.
- Read: rd_vld[i] = (count > i); rd_data[i]/rd_tstamp[i] = storage[(rd_ptr + i) mod DEPTH]; combinational from registers.
- Pop: P = number of leading ones of (rd_pop & rd_vld) from bit 0; rd_ptr += P mod DEPTH. Non-thermometer rd_pop is illegal; P counts only the contiguous prefix (assertion in RTL).
- count_next = count + W_accepted − P.
- flush: next cycle rd_ptr = wr_ptr = count = 0; same-cycle writes and pops discarded and not counted as drops; overflow/drop_cnt unaffected.
- overflow_clr: overflow and drop_cnt ← 0; a drop in the same cycle wins (overflow = 1, drop_cnt = W).
- Modular wrap: pointer + offset computed at $clog2(DEPTH)+1 bits, subtract DEPTH if ≥ DEPTH.

## Timing

- Reset (reset_n low, async): pointers, count, overflow, drop_cnt = 0; storage = 0; so rd_vld = 0, rd_data = 0, rd_tstamp = 0.
- Write in cycle N visible on rd_vld/rd_data in N+1. Pop in N removes entry from outputs in N+1.
- Simultaneous write and pop: both applied; write admission uses pre-pop count.
- Full (count = DEPTH): any W ≥ 1 dropped; W = 0 no effect. Empty: rd_pop ignored (P = 0).
- Reset asserted mid-operation: contents lost immediately; no partial group survives.

## Test plan

- Reset then idle: all outputs 0; wr_vld=8'b0000_0101, data A,B -> next cycle count=2, rd_data[0]=A, rd_data[1]=B.
- Sparse compaction: wr_vld=8'b1001_0010 (lanes 1,4,7 = X,Y,Z) -> storage order X,Y,Z; pop 2'b11 -> next cycle count=1, rd_data[0]=Z.
- Wrap: DEPTH=10, fill 8, pop 8, write 6 -> wr_ptr=4, read order preserved across index 9→0.
- Overflow: count=14 of 16, write W=3 -> nothing written, count=14, overflow=1, drop_cnt=3; repeat 100× -> drop_cnt saturates at 255; overflow_clr -> both 0.
- Concurrency: count=16, pop 2 plus write W=2 same cycle -> dropped (pre-pop rule), count=14; flush with writes -> count=0, drop_cnt unchanged.
- TSTAMP_EN=1: write 3 entries with tstamp_in=0x1234 -> rd_tstamp[0..1]=0x1234; TSTAMP_EN=0 -> rd_tstamp=0.
